// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/load-store memory port arbiter.
// Imported by mem_port_arbiter and arb_starve_ctr.
package pd_mem_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_e;

  localparam int DWIDTH = 32;
  localparam int BE_W   = DWIDTH / 8;

  // Width of a counter that must represent 0..limit inclusive.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating counter of consecutive cycles a fetch request has lost arbitration.
// hit_o rises once the count reaches LIMIT and stays high until cleared.
module arb_starve_ctr
  import pd_mem_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic hit_o
);

  localparam int CW = cnt_width(LIMIT);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < LIM)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q >= LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch (F, read-only) and load/store (D).
// Optional performance counters are enabled by defining MEM_ARB_PERF_EN.
module mem_port_arbiter
  import pd_mem_pkg::arb_state_e;
  import pd_mem_pkg::arb_owner_e;
  import pd_mem_pkg::ARB_IDLE;
  import pd_mem_pkg::ARB_WAIT;
  import pd_mem_pkg::OWN_NONE;
  import pd_mem_pkg::OWN_F;
  import pd_mem_pkg::OWN_D;
#(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                f_req_i,
  input  logic [AWIDTH-1:0]   f_addr_i,
  output logic                f_gnt_o,
  output logic                f_rvalid_o,
  output logic [DWIDTH-1:0]   f_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [AWIDTH-1:0]   d_addr_i,
  input  logic [DWIDTH-1:0]   d_wdata_i,
  input  logic [DWIDTH/8-1:0] d_be_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DWIDTH-1:0]   d_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [AWIDTH-1:0]   mem_addr_o,
  output logic [DWIDTH-1:0]   mem_wdata_o,
  output logic [DWIDTH/8-1:0] mem_be_o,
  input  logic                mem_rvalid_i,
  input  logic [DWIDTH-1:0]   mem_rdata_i
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_f_gnt_o,
  output logic [31:0]         perf_d_gnt_o,
  output logic [31:0]         perf_conflict_o
`endif
);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;

  logic starve_hit;
  logic grant_ok;
  logic resp_valid;
  logic f_gnt;
  logic d_gnt;

  // A response frees the port in the same cycle, so a new grant can overlap it.
  assign resp_valid = !rst && (state_q == ARB_WAIT) && mem_rvalid_i;
  assign grant_ok   = !rst && ((state_q == ARB_IDLE) || resp_valid);

  assign d_gnt = grant_ok && d_req_i && !(f_req_i && starve_hit);
  assign f_gnt = grant_ok && f_req_i && (!d_req_i || starve_hit);

  assign f_gnt_o = f_gnt;
  assign d_gnt_o = d_gnt;

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc_i (f_req_i && !f_gnt),
    .clr_i (!f_req_i || f_gnt),
    .hit_o (starve_hit)
  );

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (f_gnt) begin
      mem_req_o  = 1'b1;
      mem_addr_o = f_addr_i;
      mem_be_o   = '1;
    end else if (d_gnt) begin
      mem_req_o   = 1'b1;
      mem_we_o    = d_we_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
      mem_be_o    = d_be_i;
    end
  end

  assign f_rvalid_o = resp_valid && (owner_q == OWN_F);
  assign d_rvalid_o = resp_valid && (owner_q == OWN_D);
  assign f_rdata_o  = f_rvalid_o ? mem_rdata_i : '0;
  assign d_rdata_o  = d_rvalid_o ? mem_rdata_i : '0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (f_gnt) begin
      state_d = ARB_WAIT;
      owner_d = OWN_F;
    end else if (d_gnt) begin
      state_d = ARB_WAIT;
      owner_d = OWN_D;
    end else if (resp_valid) begin
      state_d = ARB_IDLE;
      owner_d = OWN_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_f_q, perf_d_q, perf_c_q;
  logic [31:0] perf_f_d, perf_d_d, perf_c_d;

  // Conflict counts raw request overlap, independent of whether a grant was possible.
  always_comb begin
    perf_f_d = perf_f_q + (f_gnt ? 32'd1 : 32'd0);
    perf_d_d = perf_d_q + (d_gnt ? 32'd1 : 32'd0);
    perf_c_d = perf_c_q + ((f_req_i && d_req_i) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_f_q <= '0;
      perf_d_q <= '0;
      perf_c_q <= '0;
    end else begin
      perf_f_q <= perf_f_d;
      perf_d_q <= perf_d_d;
      perf_c_q <= perf_c_d;
    end
  end

  assign perf_f_gnt_o    = perf_f_q;
  assign perf_d_gnt_o    = perf_d_q;
  assign perf_conflict_o = perf_c_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs change on negedge,
// combinational outputs are checked #1 later, well away from the rising edge.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req_i;
  logic [AW-1:0] f_addr_i;
  logic          f_gnt_o, f_rvalid_o;
  logic [DW-1:0] f_rdata_o;
  logic          d_req_i, d_we_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic [3:0]    d_be_i;
  logic          d_gnt_o, d_rvalid_o;
  logic [DW-1:0] d_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [3:0]    mem_be_o;
  logic          mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]   perf_f_gnt_o, perf_d_gnt_o, perf_conflict_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AWIDTH       (AW),
    .DWIDTH       (DW),
    .STARVE_LIMIT (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .f_req_i      (f_req_i),
    .f_addr_i     (f_addr_i),
    .f_gnt_o      (f_gnt_o),
    .f_rvalid_o   (f_rvalid_o),
    .f_rdata_o    (f_rdata_o),
    .d_req_i      (d_req_i),
    .d_we_i       (d_we_i),
    .d_addr_i     (d_addr_i),
    .d_wdata_i    (d_wdata_i),
    .d_be_i       (d_be_i),
    .d_gnt_o      (d_gnt_o),
    .d_rvalid_o   (d_rvalid_o),
    .d_rdata_o    (d_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_f_gnt_o    (perf_f_gnt_o),
    .perf_d_gnt_o    (perf_d_gnt_o),
    .perf_conflict_o (perf_conflict_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    f_req_i = 1'b0; f_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;

    // Reset: all outputs quiet, even with a stray memory response.
    @(negedge clk);
    step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    #1;
    check("rst_mem_req", mem_req_o, 0);
    check("rst_gnts", {f_gnt_o, d_gnt_o}, 0);
    check("rst_rvalids", {f_rvalid_o, d_rvalid_o}, 0);
    check("rst_rdata", {f_rdata_o, d_rdata_o}, 0);
    check("rst_mem_bus", {mem_we_o, mem_addr_o, mem_be_o}, 0);
    mem_rvalid_i = 1'b0;
    step();
    rst = 1'b0;

    // 1: fetch only, response two cycles after request.
    f_req_i = 1'b1; f_addr_i = 32'h0100_0000;
    #1;
    check("s1_f_gnt", {f_gnt_o, d_gnt_o}, 2'b10);
    check("s1_mem", {mem_req_o, mem_we_o, mem_be_o}, 6'b10_1111);
    check("s1_addr", mem_addr_o, 32'h0100_0000);
    step();
    f_req_i = 1'b0;
    #1;
    check("s1_wait_noreq", {mem_req_o, f_rvalid_o}, 0);
    step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0013;
    #1;
    check("s1_rvalid", {f_rvalid_o, d_rvalid_o}, 2'b10);
    check("s1_rdata", f_rdata_o, 32'h0000_0013);
    step();
    // Idle response is dropped.
    #1;
    check("s1_idle_drop", {f_rvalid_o, d_rvalid_o}, 0);
    mem_rvalid_i = 1'b0;
    step();

    // 2: contention, memory answering every cycle; F wins the 5th opportunity.
    f_req_i = 1'b1; f_addr_i = 32'h0100_0000;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0100_0100;
    #1;
    check("s2_op1_gnt", {f_gnt_o, d_gnt_o}, 2'b01);
    check("s2_op1_addr", mem_addr_o, 32'h0100_0100);
    for (int k = 2; k <= 4; k++) begin
      step();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0020 + k;
      #1;
      check($sformatf("s2_op%0d_gnt", k), {f_gnt_o, d_gnt_o}, 2'b01);
      check($sformatf("s2_op%0d_rsp", k), {d_rvalid_o, d_rdata_o}, {1'b1, 32'h0000_0020 + k});
    end
    step();
    #1;
    check("s2_op5_gnt", {f_gnt_o, d_gnt_o}, 2'b10);
    check("s2_op5_addr", {mem_addr_o, mem_be_o}, {32'h0100_0000, 4'hF});
    check("s2_op5_rsp", {f_rvalid_o, d_rvalid_o}, 2'b01);
    step();
    f_req_i = 1'b0; mem_rdata_i = 32'h0000_AAAA;
    #1;
    check("s2_f_rsp", {f_rvalid_o, d_rvalid_o, f_rdata_o}, {2'b10, 32'h0000_AAAA});
    check("s2_d_regrant", d_gnt_o, 1);
    step();
    d_req_i = 1'b0; mem_rdata_i = 32'h0000_0055;
    #1;
    check("s2_d_last", {d_rvalid_o, mem_req_o}, 2'b10);
    step();
    mem_rvalid_i = 1'b0;
`ifdef MEM_ARB_PERF_EN
    // Since reset: 2 F grants, 5 D grants, 5 cycles with both requesting.
    check("perf_f", perf_f_gnt_o, 2);
    check("perf_d", perf_d_gnt_o, 5);
    check("perf_conflict", perf_conflict_o, 5);
`endif

    // 3: store with partial byte enables.
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h0100_0200;
    d_wdata_i = 32'hDEAD_BEEF; d_be_i = 4'h3;
    #1;
    check("s3_gnt", {d_gnt_o, mem_req_o, mem_we_o}, 3'b111);
    check("s3_bus", {mem_addr_o, mem_wdata_o, mem_be_o}, {32'h0100_0200, 32'hDEAD_BEEF, 4'h3});
    step();
    d_req_i = 1'b0; d_we_i = 1'b0; mem_rvalid_i = 1'b1;
    #1;
    check("s3_ack", {d_rvalid_o, f_rvalid_o}, 2'b10);
    step();
    mem_rvalid_i = 1'b0;

    // 4: back-to-back loads, one issue per response cycle.
    d_req_i = 1'b1; d_addr_i = 32'h0100_0300;
    #1;
    check("s4_first", {mem_req_o, d_gnt_o}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      step();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0100 + i;
      #1;
      check($sformatf("s4_b2b%0d", i), {mem_req_o, d_gnt_o, d_rvalid_o}, 3'b111);
      check($sformatf("s4_rdata%0d", i), d_rdata_o, 32'h0000_0100 + i);
    end
    step();
    d_req_i = 1'b0;
    #1;
    check("s4_drain", {mem_req_o, d_rvalid_o}, 2'b01);
    step();
    mem_rvalid_i = 1'b0;

    // 5: reset while a fetch is outstanding; its late response must vanish.
    f_req_i = 1'b1; f_addr_i = 32'h0100_0400;
    #1;
    check("s5_gnt", f_gnt_o, 1);
    step();
    f_req_i = 1'b0; rst = 1'b1;
    #1;
    check("s5_rst_quiet", {f_gnt_o, mem_req_o}, 0);
    step();
    rst = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0077;
    #1;
    check("s5_dropped", {f_rvalid_o, d_rvalid_o, f_rdata_o}, 0);
`ifdef MEM_ARB_PERF_EN
    check("s5_perf_clr", {perf_f_gnt_o, perf_d_gnt_o, perf_conflict_o}, 0);
`endif
    step();
    mem_rvalid_i = 1'b0; f_req_i = 1'b1;
    #1;
    check("s5_idle_gnt", {f_gnt_o, mem_req_o}, 2'b11);
    step();
    f_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0088;
    #1;
    check("s5_rsp", {f_rvalid_o, f_rdata_o}, {1'b1, 32'h0000_0088});
    step();
    mem_rvalid_i = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
